trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, width of captured PC and ALU result.
REQ-002 SHALL have parameter DEPTH, default 16, buffer entries; power of 2, at least 4.
REQ-003 SHALL have parameter POST_TRIG, default 4, samples stored from trigger onward, inclusive; range 1..DEPTH.
REQ-004 SHALL have port clk1, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset1, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port valid_in, input, 1 bit: one retired instruction sample this cycle.
REQ-007 SHALL have ports pc_in [DATA_W], opcode_in [3], alu_result_in [DATA_W] and memwrite_in [1], all inputs: sample fields.
REQ-008 SHALL have port arm, input, 1 bit: single-cycle pulse; starts or restarts a capture.
REQ-009 SHALL have port trig_mode, input, 2 bits: 00 immediate, 01 PC equals trig_pc, 10 opcode equals trig_opcode, 11 memwrite_in high.
REQ-010 SHALL have ports trig_pc [DATA_W] and trig_opcode [3], inputs: trigger compare values.
REQ-011 SHALL have port rd_en, input, 1 bit: pop the oldest entry.
REQ-012 SHALL have port rd_data, output, 2*DATA_W+4 bits: {pc, alu_result, opcode, memwrite}.
REQ-013 SHALL have port rd_valid, output, 1 bit: rd_data holds a popped entry.
REQ-014 SHALL have port state, output, 2 bits: 00 IDLE, 01 ARMED, 10 POST, 11 DONE.
REQ-015 SHALL have port count, output, clog2(DEPTH)+1 bits: entries held.

Function
REQ-016 In IDLE, the block SHALL ignore samples; arm moves it to ARMED with count 0 and write pointer 0.
REQ-017 In ARMED, each valid_in SHALL write one entry at the write pointer, increment the pointer modulo DEPTH and saturate count at DEPTH; older entries are overwritten on wrap.
REQ-018 Trigger SHALL be evaluated only in ARMED and only on valid_in cycles, using that cycle's sample; a hit moves the block to POST and the trigger sample is post-sample 1.
REQ-019 The sample arriving on the same cycle as arm SHALL be neither stored nor evaluated.
REQ-020 In POST, each valid_in SHALL be stored; once POST_TRIG post-samples are stored the block SHALL enter DONE on that edge; POST_TRIG=1 goes ARMED->DONE directly.
REQ-021 In DONE, samples SHALL be ignored, and the oldest entry is at (write pointer - count) mod DEPTH.
REQ-022 In DONE, rd_en with count>0 SHALL register the oldest entry into rd_data, assert rd_valid the next cycle for exactly one cycle, and decrement count.
REQ-023 When count reaches 0 through a pop, the block SHALL return to IDLE on the same edge.
REQ-024 rd_en with count=0 or outside DONE SHALL be ignored, and rd_valid stays 0.
REQ-025 arm in any state other than IDLE SHALL discard all contents and restart ARMED with count 0; arm has priority over rd_en and valid_in on the same cycle.
REQ-026 Trigger configuration inputs SHALL be sampled combinationally and SHALL be held stable by the user while in ARMED.

Reset
REQ-027 When reset1 is low, the block SHALL immediately force state=IDLE, count=0, pointers=0, rd_valid=0 and rd_data=0, including mid-capture or mid-readout.
REQ-028 Buffer contents SHALL NOT be reset and are unreachable until rewritten.

Structure
REQ-029 Package trace_pkg SHALL hold the state encoding, the trig_mode encoding and the entry-width function 2*DATA_W+4.
REQ-030 Storage SHALL be sub-module trace_ram: DEPTH x entry width, one write port, one synchronous-read port, no reset.

Verification (DATA_W=8, DEPTH=16, POST_TRIG=4)
REQ-031 Reset: hold reset1 low with random inputs -> state=00, count=0, rd_valid=0 and rd_data=0 asynchronously.
REQ-032 Immediate trigger: arm, then pc=0x00..0x05 valid every cycle -> DONE after pc 0x03 with count=4; four pops return pc 0x00, 0x01, 0x02, 0x03, then state=IDLE.
REQ-033 PC trigger with wrap: trig_pc=0x14, pc=0x00..0x3F -> DONE after pc 0x17 with count=16; pops return pc 0x08..0x17 in order.
REQ-034 memwrite trigger with gaps: valid_in every third cycle, memwrite_in high only at pc=0x09 -> post-samples are pc 0x09..0x0C, and no entries are written on invalid cycles.
REQ-035 Mid-operation events: reset1 low during POST -> IDLE and count=0; arm during DONE with count=7 -> ARMED and count=0; rd_en at count=0 -> no rd_valid.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared encodings and sizing helpers for the instruction trace capture block.
package trace_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ARMED = 2'b01;
  localparam logic [1:0] ST_POST  = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [1:0] TRIG_IMM   = 2'b00;
  localparam logic [1:0] TRIG_PC    = 2'b01;
  localparam logic [1:0] TRIG_OP    = 2'b10;
  localparam logic [1:0] TRIG_MEMWR = 2'b11;

  // Entry layout is {pc, alu_result, opcode[2:0], memwrite}.
  function automatic int unsigned entry_w(input int unsigned data_w);
    return 2 * data_w + 4;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one write port, one registered read port, contents never reset.
module trace_ram #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       re_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]           rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_capture.sv
// Triggered instruction trace buffer: rolling pre-trigger history plus a fixed
// number of post-trigger samples, drained oldest-first once capture completes.
module trace_capture
  import trace_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4
) (
  input  logic                        clk1,
  input  logic                        reset1,
  input  logic                        valid_in,
  input  logic [DATA_W-1:0]           pc_in,
  input  logic [2:0]                  opcode_in,
  input  logic [DATA_W-1:0]           alu_result_in,
  input  logic                        memwrite_in,
  input  logic                        arm,
  input  logic [1:0]                  trig_mode,
  input  logic [DATA_W-1:0]           trig_pc,
  input  logic [2:0]                  trig_opcode,
  input  logic                        rd_en,
  output logic [2*DATA_W+3:0]         rd_data,
  output logic                        rd_valid,
  output logic [1:0]                  state,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = entry_w(DATA_W);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_q, post_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_seen_q, rd_seen_d;

  logic          trig_hit;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_raddr;
  logic [EW-1:0] ram_wdata, ram_rdata;

  always_comb begin
    trig_hit = 1'b0;
    unique case (trig_mode)
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_PC:    trig_hit = (pc_in == trig_pc);
      TRIG_OP:    trig_hit = (opcode_in == trig_opcode);
      TRIG_MEMWR: trig_hit = memwrite_in;
      default:    trig_hit = 1'b0;
    endcase
  end

  assign ram_wdata = {pc_in, alu_result_in, opcode_in, memwrite_in};
  // Oldest entry; a full buffer (count == DEPTH) wraps to the write pointer itself.
  assign ram_raddr = wr_ptr_q - count_q[AW-1:0];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_valid_d = 1'b0;
    rd_seen_d  = rd_seen_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    if (arm) begin
      state_d  = ST_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
    end else begin
      unique case (state_q)
        ST_ARMED, ST_POST: begin
          if (valid_in) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
            if (state_q == ST_ARMED) begin
              if (trig_hit) begin
                post_d  = CW'(1);
                state_d = (POST_TRIG == 1) ? ST_DONE : ST_POST;
              end
            end else begin
              post_d = post_q + 1'b1;
              if (post_q + 1'b1 == CW'(POST_TRIG)) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (rd_en && (count_q != '0)) begin
            ram_re     = 1'b1;
            rd_valid_d = 1'b1;
            rd_seen_d  = 1'b1;
            count_d    = count_q - 1'b1;
            if (count_q == CW'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk1 or negedge reset1) begin
    if (!reset1) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  trace_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk1),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // The RAM read register has no reset, so gate it until a pop has loaded it.
  assign rd_data  = rd_seen_q ? ram_rdata : '0;
  assign rd_valid = rd_valid_q;
  assign state    = state_q;
  assign count    = count_q;

endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: expected pops are queued as stimulus is
// driven and compared whenever rd_valid is seen.
module tb_trace_capture;

  logic        clk1;
  logic        reset1;
  logic        valid_in;
  logic [7:0]  pc_in;
  logic [2:0]  opcode_in;
  logic [7:0]  alu_result_in;
  logic        memwrite_in;
  logic        arm;
  logic [1:0]  trig_mode;
  logic [7:0]  trig_pc;
  logic [2:0]  trig_opcode;
  logic        rd_en;
  logic [19:0] rd_data;
  logic        rd_valid;
  logic [1:0]  state;
  logic [4:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [19:0] exp_q[$];

  trace_capture #(
    .DATA_W    (8),
    .DEPTH     (16),
    .POST_TRIG (4)
  ) dut (
    .clk1          (clk1),
    .reset1        (reset1),
    .valid_in      (valid_in),
    .pc_in         (pc_in),
    .opcode_in     (opcode_in),
    .alu_result_in (alu_result_in),
    .memwrite_in   (memwrite_in),
    .arm           (arm),
    .trig_mode     (trig_mode),
    .trig_pc       (trig_pc),
    .trig_opcode   (trig_opcode),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .state         (state),
    .count         (count)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] ent(input logic [7:0] pc, input logic mw);
    return {pc, pc ^ 8'h5A, pc[2:0], mw};
  endfunction

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic feed(input logic [7:0] pc, input logic mw);
    valid_in      = 1'b1;
    pc_in         = pc;
    alu_result_in = pc ^ 8'h5A;
    opcode_in     = pc[2:0];
    memwrite_in   = mw;
    step();
    valid_in    = 1'b0;
    memwrite_in = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    step();
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("idle_after_drain", state, 2'b00);
    check_eq("count_after_drain", count, 0);
    check_eq("rd_valid_one_cycle", rd_valid, 1'b0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk1) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_pop", rd_valid, 1'b0);
      end else begin
        check_eq("pop_data", rd_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset1 = 1'b0; valid_in = 0; pc_in = 0; opcode_in = 0; alu_result_in = 0;
    memwrite_in = 0; arm = 0; trig_mode = 0; trig_pc = 0; trig_opcode = 0; rd_en = 0;

    // Reset held low with random activity.
    #3;
    check_eq("rst_state", state, 2'b00);
    check_eq("rst_count", count, 0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_rd_data", rd_data, 0);
    repeat (4) begin
      step();
      valid_in = 1'($urandom); arm = 1'($urandom); rd_en = 1'($urandom);
      pc_in = 8'($urandom); memwrite_in = 1'($urandom); trig_mode = 2'($urandom);
      #2;
      check_eq("rst_hold_state", state, 2'b00);
      check_eq("rst_hold_count", count, 0);
      check_eq("rst_hold_rd_valid", rd_valid, 1'b0);
      check_eq("rst_hold_rd_data", rd_data, 0);
    end
    step();
    valid_in = 0; arm = 0; rd_en = 0; memwrite_in = 0; trig_mode = 2'b00;
    reset1 = 1'b1;
    step();

    // Immediate trigger; the sample on the arm cycle must not be stored.
    arm = 1'b1;
    feed(8'hFF, 1'b0);
    arm = 1'b0;
    check_eq("imm_armed", state, 2'b01);
    check_eq("imm_armed_count", count, 0);
    for (int i = 0; i < 6; i++) begin
      feed(8'(i), 1'b0);
      if (i == 0) check_eq("imm_post", state, 2'b10);
      if (i == 0) check_eq("imm_post_count", count, 1);
      if (i == 3) check_eq("imm_done", state, 2'b11);
    end
    check_eq("imm_done_count", count, 4);
    for (int i = 0; i < 4; i++) exp_q.push_back(ent(8'(i), 1'b0));
    pop_n(4);
    rd_en = 1'b1;
    step();
    step();
    rd_en = 1'b0;
    check_eq("rd_en_idle_no_valid", rd_valid, 1'b0);
    check_eq("rd_en_idle_state", state, 2'b00);

    // PC trigger with buffer wrap.
    trig_mode = 2'b01; trig_pc = 8'h14;
    arm_pulse();
    for (int i = 0; i < 64; i++) begin
      feed(8'(i), 1'b0);
      if (i == 8'h13) check_eq("pc_pre_armed", state, 2'b01);
      if (i == 8'h13) check_eq("pc_pre_sat", count, 16);
      if (i == 8'h17) check_eq("pc_done", state, 2'b11);
    end
    check_eq("pc_done_count", count, 16);
    for (int i = 8; i <= 8'h17; i++) exp_q.push_back(ent(8'(i), 1'b0));
    pop_n(16);

    // Reset during POST; rd_data still holds the last popped entry here.
    trig_mode = 2'b01; trig_pc = 8'h03;
    arm_pulse();
    rd_en = 1'b1;
    feed(8'h00, 1'b0);
    feed(8'h01, 1'b0);
    rd_en = 1'b0;
    check_eq("rd_en_armed_no_valid", rd_valid, 1'b0);
    feed(8'h02, 1'b0);
    feed(8'h03, 1'b0);
    feed(8'h04, 1'b0);
    check_eq("mid_post_state", state, 2'b10);
    check_eq("mid_post_count", count, 5);
    #2 reset1 = 1'b0;
    #1;
    check_eq("mid_rst_state", state, 2'b00);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_rd_data", rd_data, 0);
    check_eq("mid_rst_rd_valid", rd_valid, 1'b0);
    step();
    reset1 = 1'b1;
    step();

    // Re-arm in DONE with 7 entries; arm wins over a simultaneous rd_en.
    arm_pulse();
    for (int i = 0; i < 7; i++) feed(8'(i), 1'b0);
    check_eq("done7_state", state, 2'b11);
    check_eq("done7_count", count, 7);
    arm = 1'b1; rd_en = 1'b1;
    step();
    arm = 1'b0; rd_en = 1'b0;
    check_eq("rearm_state", state, 2'b01);
    check_eq("rearm_count", count, 0);
    check_eq("rearm_no_valid", rd_valid, 1'b0);

    // memwrite trigger with gaps; idle cycles carry junk including memwrite high.
    trig_mode = 2'b11;
    arm_pulse();
    for (int k = 0; k < 13; k++) begin
      pc_in = 8'hEE; memwrite_in = 1'b1;
      step();
      step();
      memwrite_in = 1'b0;
      feed(8'(k), k == 9);
      if (k == 8) check_eq("mw_armed", state, 2'b01);
      if (k == 8) check_eq("mw_armed_count", count, 9);
      if (k == 9) check_eq("mw_post", state, 2'b10);
      if (k == 12) check_eq("mw_done", state, 2'b11);
    end
    check_eq("mw_done_count", count, 13);
    for (int k = 0; k < 13; k++) exp_q.push_back(ent(8'(k), k == 9));
    pop_n(13);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
